// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: fetch PC, instruction memory, IF/ID register
// Branch redirects are relative to the IF/ID pc, and a taken branch injects a NOP bubble.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [63:0]                   branch_offset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [63:0]                   pc,
  output logic [31:0]                   Instruction,
  output logic [6:0]                    Opcode,
  output logic [3:0]                    Funct,
  output logic                          valid
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] imem_q [IMEM_DEPTH];

  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_word;

  // Memory has no reset so a program loaded during reset survives it.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[imem_addr] <= imem_wdata;
    end
  end

  // Combinational read sees pre-edge contents, so a same-cycle write returns old data.
  assign fetch_word = imem_q[fetch_pc_q[AW+1:2]];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (reset) begin
      fetch_pc_d = RESET_PC;
      pc_d       = 64'h0;
      instr_d    = NOP;
      valid_d    = 1'b0;
    end else if (branch_taken) begin
      fetch_pc_d = pc_q + branch_offset;
      instr_d    = NOP;
      valid_d    = 1'b0;
    end else if (!stall) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
      pc_d       = fetch_pc_q;
      instr_d    = fetch_word;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    pc_q       <= pc_d;
    instr_q    <= instr_d;
    valid_q    <= valid_d;
  end

  assign pc          = pc_q;
  assign Instruction = instr_q;
  assign valid       = valid_q;
  assign Opcode      = instr_q[6:0];
  assign Funct       = {instr_q[30], instr_q[14:12]};

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch
module tb_instr_fetch;

  localparam int IMEM_DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_we;
  logic [63:0] branch_offset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] pc;
  logic [31:0] Instruction;
  logic [6:0]  Opcode;
  logic [3:0]  Funct;
  logic        valid;

  int checks = 0;
  int fails  = 0;

  instr_fetch #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc), .Instruction(Instruction),
    .Opcode(Opcode), .Funct(Funct), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [63:0] off;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [6:0]  e_op;
    logic [3:0]  e_funct;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stl, logic br, logic [63:0] off,
                              logic we, logic [5:0] waddr, logic [31:0] wdata,
                              logic [63:0] e_pc, logic [31:0] e_instr, logic e_valid,
                              logic [6:0] e_op, logic [3:0] e_funct);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.off = off;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
    v.e_op = e_op; v.e_funct = e_funct;
    return v;
  endfunction

  task automatic check_outputs(string tag, logic [63:0] e_pc, logic [31:0] e_instr,
                               logic e_valid, logic [6:0] e_op, logic [3:0] e_funct);
    checks += 5;
    if (pc !== e_pc) begin
      fails++; $display("FAIL %s pc: got %h expected %h", tag, pc, e_pc);
    end
    if (Instruction !== e_instr) begin
      fails++; $display("FAIL %s Instruction: got %h expected %h", tag, Instruction, e_instr);
    end
    if (valid !== e_valid) begin
      fails++; $display("FAIL %s valid: got %b expected %b", tag, valid, e_valid);
    end
    if (Opcode !== e_op) begin
      fails++; $display("FAIL %s Opcode: got %b expected %b", tag, Opcode, e_op);
    end
    if (Funct !== e_funct) begin
      fails++; $display("FAIL %s Funct: got %b expected %b", tag, Funct, e_funct);
    end
  endtask

  task automatic load_word(logic [5:0] a, logic [31:0] d);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    @(posedge clk); @(negedge clk);
    imem_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 64'h0;
    imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;

    //          rst stl br  off             we addr wdata          pc                      instr          v  op       funct
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0033, 1, 7'h33, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 1, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 1, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 1, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd8,                 32'h0000_7033, 1, 7'h33, 4'h7));
    // branch -8 from pc 8, then plain fetch from 0
    vecs.push_back(mk(0, 0, 1, -64'd8,        0, 6'd0, 32'h0, 64'd8,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0033, 1, 7'h33, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd8,                 32'h0000_7033, 1, 7'h33, 4'h7));
    // branch with stall behaves the same
    vecs.push_back(mk(0, 1, 1, -64'd8,        0, 6'd0, 32'h0, 64'd8,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0033, 1, 7'h33, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h4000_0033, 1, 7'h33, 4'h8));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd8,                 32'h0000_7033, 1, 7'h33, 4'h7));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd12,                32'h0000_6033, 1, 7'h33, 4'h6));
    // reset mid-stream, then write collision at fetch_pc 0
    vecs.push_back(mk(1, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         1, 6'd0, 32'h3, 64'd0,                 32'h0000_0033, 1, 7'h33, 4'h0));
    vecs.push_back(mk(0, 0, 1, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0003, 1, 7'h03, 4'h0));
    // memory index wraps at 256; fetch_pc wraps past 2^64
    vecs.push_back(mk(0, 0, 1, 64'd256,       0, 6'd0, 32'h0, 64'd0,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd256,               32'h0000_0003, 1, 7'h03, 4'h0));
    vecs.push_back(mk(0, 0, 1, -64'd260,      0, 6'd0, 32'h0, 64'd256,               NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h4000_5033, 1, 7'h33, 4'hD));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0003, 1, 7'h03, 4'h0));
    // bubble held by stall while memory is written
    vecs.push_back(mk(0, 0, 1, 64'd4,         0, 6'd0, 32'h0, 64'd0,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 1, 0, 64'd0,         1, 6'd1, 32'h0020_8033, 64'd0,         NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd4,                 32'h0020_8033, 1, 7'h33, 4'h0));
    // reset wins over branch and stall
    vecs.push_back(mk(1, 1, 1, 64'd100,       0, 6'd0, 32'h0, 64'd0,                 NOP,           0, 7'h13, 4'h0));
    vecs.push_back(mk(0, 0, 0, 64'd0,         0, 6'd0, 32'h0, 64'd0,                 32'h0000_0003, 1, 7'h03, 4'h0));

    @(negedge clk);
    load_word(6'd0,  32'h0000_0033);
    load_word(6'd1,  32'h4000_0033);
    load_word(6'd2,  32'h0000_7033);
    load_word(6'd3,  32'h0000_6033);
    load_word(6'd63, 32'h4000_5033);
    check_outputs("reset_state", 64'd0, NOP, 1'b0, 7'h13, 4'h0);

    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_offset = vecs[i].off;
      imem_we       = vecs[i].we;
      imem_addr     = vecs[i].waddr;
      imem_wdata    = vecs[i].wdata;
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_valid, vecs[i].e_op, vecs[i].e_funct);
    end

    // Outputs must not move between edges: drop all controls mid-cycle and re-check.
    reset = 1'b0; stall = 1'b1; branch_taken = 1'b0; imem_we = 1'b0;
    @(posedge clk); #2;
    check_outputs("hold_early", 64'd0, 32'h0000_0003, 1'b1, 7'h03, 4'h0);
    stall = 1'b0;
    #2;
    check_outputs("hold_late", 64'd0, 32'h0000_0003, 1'b1, 7'h03, 4'h0);
    @(posedge clk); @(negedge clk);
    check_outputs("after_hold", 64'd4, 32'h0020_8033, 1'b1, 7'h33, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, SHALL set the instruction memory depth in 32-bit words; it SHALL be a power of two.
REQ-002 Parameter RESET_PC, default 64'h0, SHALL set the fetch PC loaded on reset.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port stall, input, 1: hold the fetch PC and the IF/ID outputs.
REQ-006 Port branch_taken, input, 1: redirect the fetch to the branch target.
REQ-007 Port branch_offset, input, 64: signed byte offset, added to the pc output to form the branch target.
REQ-008 Port imem_we, input, 1: instruction memory write enable.
REQ-009 Port imem_addr, input, log2(IMEM_DEPTH): instruction memory word address for writes.
REQ-010 Port imem_wdata, input, 32: instruction word to write.
REQ-011 Port pc, output, 64: byte address of the instruction held in IF/ID.
REQ-012 Port Instruction, output, 32: the instruction word held in IF/ID.
REQ-013 Port Opcode, output, 7: equal to Instruction[6:0].
REQ-014 Port Funct, output, 4: equal to {Instruction[30], Instruction[14:12]}, which the control stage expects.
REQ-015 Port valid, output, 1: IF/ID holds a real instruction (not a bubble).

Function
REQ-016 The block SHALL hold an internal 64-bit fetch_pc register and an IF/ID register containing pc, Instruction and valid.
REQ-017 The instruction memory read SHALL be combinational at word index fetch_pc[log2(IMEM_DEPTH)+1:2].
- fetch_pc[1:0] are ignored.
- Higher bits wrap modulo IMEM_DEPTH.
REQ-018 Normal cycle (no reset, no branch_taken, no stall), all on one edge:
- IF/ID SHALL capture {fetch_pc, imem[fetch_pc], valid=1}.
- fetch_pc SHALL become fetch_pc+4, with 64-bit wrap-around.
REQ-019 Fetch latency SHALL be one cycle: the word at fetch_pc appears on Instruction after the next rising edge.
REQ-020 Stall without branch_taken: fetch_pc and all IF/ID outputs SHALL hold their values.
REQ-021 branch_taken=1, regardless of stall:
- fetch_pc SHALL become pc + branch_offset, where pc is the current output value, truncated to 64 bits.
- valid SHALL become 0.
- Instruction SHALL become 32'h00000013 (NOP), so Opcode=7'b0010011 and Funct=4'b0000.
- pc SHALL hold its value.
REQ-022 After a branch, the instruction at the target SHALL appear with valid=1 one edge later, unless stall or another branch intervenes.
REQ-023 Memory writes:
- When imem_we=1, imem[imem_addr] SHALL be written on the rising edge.
- A fetch from the same word in the same cycle SHALL return the old contents.
- Writes SHALL proceed during stall and during reset.
REQ-024 Opcode and Funct SHALL be pure combinational slices of the registered Instruction, with no extra latency.
REQ-025 No output SHALL change between rising edges except through the combinational Opcode/Funct slicing of Instruction.

Reset
REQ-026 When reset=1 at a rising edge:
- fetch_pc SHALL become RESET_PC.
- pc SHALL become 0.
- Instruction SHALL become 32'h00000013.
- valid SHALL become 0.
- reset SHALL override stall and branch_taken.
REQ-027 Reset SHALL NOT clear the instruction memory contents.
REQ-028 The first edge with reset=0 and stall=0 SHALL present the word at RESET_PC with valid=1.
REQ-029 Reset asserted mid-stream SHALL discard the IF/ID contents on that same edge.

Verification
REQ-030 Sequential fetch:
- Stimulus: preload imem[0..3] = 0x00000033, 0x40000033, 0x00007033, 0x00006033; release reset.
- Response: on 4 successive edges pc = 0, 4, 8, 12; Opcode = 7'b0110011; Funct = 0000, 1000, 0111, 0110; valid = 1.
REQ-031 Stall:
- Stimulus: assert stall for 3 cycles while pc = 4.
- Response: pc = 4 and Instruction = 0x40000033 held throughout; pc = 8 on the first edge after stall drops.
REQ-032 Branch:
- Stimulus: with pc = 8 (imem[2] = 0x00007033), set branch_taken = 1, branch_offset = -8.
- Response: next edge valid = 0 with Instruction = 0x00000013; following edge pc = 0 with Instruction = 0x00000033 and valid = 1.
REQ-033 Branch over stall:
- Stimulus: assert branch_taken and stall together.
- Response: identical to REQ-032.
REQ-034 Reset mid-stream and write collision:
- Reset stimulus: assert reset while valid = 1 at pc = 12.
- Reset response: next edge valid = 0 and pc = 0; memory contents intact.
- Collision stimulus: write imem[0] = 0x00000003 in the same cycle fetch_pc = 0.
- Collision response: the old word is fetched; 0x00000003 (Opcode 7'b0000011) appears on the next fetch of address 0.
REQ-035 Wrap:
- Stimulus: with IMEM_DEPTH = 64, fetch at fetch_pc = 256.
- Response: imem[0] is returned.
